// File: rtl/drac_pkg.sv
// Shared fetch-side types and constants for the icache interface.
package drac_pkg;

   localparam int ICACHE_LINE_W   = 128;
   localparam int ICACHE_OFFSET_W = 4;
   localparam int ICACHE_ADDR_W   = 40;
   localparam int ICACHE_TAG_W    = ICACHE_ADDR_W - ICACHE_OFFSET_W;
   localparam int ICACHE_INSTR_W  = 32;

   typedef enum logic [1:0] {
      IDLE,
      REQ,
      WAIT,
      DROP
   } icache_if_state_t;

   typedef struct packed {
      logic                     valid;
      logic [ICACHE_TAG_W-1:0]  tag;
      logic [ICACHE_LINE_W-1:0] data;
   } icache_line_buf_t;

   function automatic logic [ICACHE_INSTR_W-1:0] icache_word_sel(
      input logic [ICACHE_LINE_W-1:0] line,
      input logic [1:0]               word
   );
      return line[word*ICACHE_INSTR_W +: ICACHE_INSTR_W];
   endfunction

endpackage

// File: rtl/icache_line_buffer.sv
// Single-line fetch buffer: tag compare and word select are combinational, fill/invalidate take effect next cycle.
// Invalidate wins over fill so a faulting or flushed line never becomes hittable.
module icache_line_buffer
   import drac_pkg::*;
(
   input  logic                      clk_i,
   input  logic                      rstn_i,
   input  logic                      i_fill,
   input  logic [ICACHE_TAG_W-1:0]   i_fill_tag,
   input  logic [ICACHE_LINE_W-1:0]  i_fill_data,
   input  logic                      i_inval,
   input  logic [ICACHE_TAG_W-1:0]   i_lookup_tag,
   input  logic [1:0]                i_lookup_word,
   output logic                      o_hit,
   output logic [ICACHE_INSTR_W-1:0] o_word
);

   icache_line_buf_t r_buf;

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_buf <= '0;
      end else if (i_inval) begin
         r_buf.valid <= 1'b0;
      end else if (i_fill) begin
         r_buf.valid <= 1'b1;
         r_buf.tag   <= i_fill_tag;
         r_buf.data  <= i_fill_data;
      end
   end

   assign o_hit  = r_buf.valid && (r_buf.tag == i_lookup_tag);
   assign o_word = icache_word_sel(r_buf.data, i_lookup_word);

endmodule

// File: rtl/icache_interface.sv
// IF-stage to icache adapter with one outstanding line request; miss = response+1 cycle, output held while stall_i.
// ICACHE_LINE_BUF_EN adds a one-line buffer giving 1-cycle hits; fetch_ready_o drops while busy or output is stalled.
module icache_interface
   import drac_pkg::*;
#(
   parameter int ADDR_W  = 40,
   parameter int LINE_W  = 128,
   parameter int INSTR_W = 32
) (
   input  logic               clk_i,
   input  logic               rstn_i,
   input  logic               fetch_valid_i,
   input  logic [ADDR_W-1:0]  fetch_pc_i,
   input  logic               stall_i,
   input  logic               flush_i,
   output logic               fetch_ready_o,
   output logic               instr_valid_o,
   output logic [INSTR_W-1:0] instr_o,
   output logic [ADDR_W-1:0]  instr_pc_o,
   output logic               instr_xcpt_o,
   output logic               icache_req_valid_o,
   input  logic               icache_req_ready_i,
   output logic [ADDR_W-1:0]  icache_req_addr_o,
   output logic               icache_kill_o,
   input  logic               icache_resp_valid_i,
   input  logic [LINE_W-1:0]  icache_resp_data_i,
   input  logic               icache_resp_xcpt_i
);

   icache_if_state_t   r_state, w_state_nxt;
   logic [ADDR_W-1:0]  r_pc;
   logic [ADDR_W-1:0]  r_instr_pc;
   logic [INSTR_W-1:0] r_instr;
   logic               r_instr_valid;
   logic               r_instr_xcpt;

   logic               w_fetch_acc;
   logic               w_resp_take;
   logic               w_hit;
   logic               w_req_valid;
   logic               w_kill;
   logic [INSTR_W-1:0] w_resp_word;
   logic [INSTR_W-1:0] w_hit_word;

   assign fetch_ready_o = rstn_i && (r_state == IDLE) && (!r_instr_valid || !stall_i);
   assign w_fetch_acc   = fetch_valid_i && fetch_ready_o;
   assign w_resp_take   = (r_state == WAIT) && icache_resp_valid_i && !flush_i;
   assign w_resp_word   = icache_resp_data_i[r_pc[3:2]*INSTR_W +: INSTR_W];

`ifdef ICACHE_LINE_BUF_EN
   logic w_buf_hit;

   icache_line_buffer u_line_buf (
      .clk_i         (clk_i),
      .rstn_i        (rstn_i),
      .i_fill        (w_resp_take && !icache_resp_xcpt_i),
      .i_fill_tag    (r_pc[ADDR_W-1:ICACHE_OFFSET_W]),
      .i_fill_data   (icache_resp_data_i),
      .i_inval       (flush_i || (icache_resp_valid_i && icache_resp_xcpt_i &&
                                  (r_state == WAIT || r_state == DROP))),
      .i_lookup_tag  (fetch_pc_i[ADDR_W-1:ICACHE_OFFSET_W]),
      .i_lookup_word (fetch_pc_i[3:2]),
      .o_hit         (w_buf_hit),
      .o_word        (w_hit_word)
   );

   // A flush in the same cycle invalidates the buffer, so it must also block the hit.
   assign w_hit = w_fetch_acc && w_buf_hit && !flush_i;
`else
   assign w_hit      = 1'b0;
   assign w_hit_word = '0;
`endif

   always_comb begin
      w_state_nxt = r_state;
      w_req_valid = 1'b0;
      w_kill      = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_fetch_acc && !w_hit) w_state_nxt = REQ;
         end
         REQ: begin
            // Flush withdraws the request unless the icache takes it this very cycle.
            w_req_valid = !flush_i || icache_req_ready_i;
            if (flush_i) begin
               if (icache_req_ready_i) begin
                  w_kill      = 1'b1;
                  w_state_nxt = DROP;
               end else begin
                  w_state_nxt = IDLE;
               end
            end else if (icache_req_ready_i) begin
               w_state_nxt = WAIT;
            end
         end
         WAIT: begin
            if (icache_resp_valid_i) begin
               w_state_nxt = IDLE;
            end else if (flush_i) begin
               w_kill      = 1'b1;
               w_state_nxt = DROP;
            end
         end
         DROP: begin
            if (icache_resp_valid_i) w_state_nxt = IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk_i or negedge rstn_i) begin
      if (!rstn_i) begin
         r_state       <= IDLE;
         r_pc          <= '0;
         r_instr_valid <= 1'b0;
         r_instr       <= '0;
         r_instr_pc    <= '0;
         r_instr_xcpt  <= 1'b0;
      end else begin
         r_state <= w_state_nxt;
         if (w_fetch_acc) r_pc <= fetch_pc_i;
         if (w_resp_take || w_hit) begin
            r_instr_valid <= 1'b1;
            r_instr       <= w_hit ? w_hit_word : w_resp_word;
            r_instr_pc    <= w_hit ? fetch_pc_i : r_pc;
            r_instr_xcpt  <= w_hit ? 1'b0 : icache_resp_xcpt_i;
         end else if (flush_i || !stall_i) begin
            r_instr_valid <= 1'b0;
         end
      end
   end

   assign instr_valid_o      = r_instr_valid;
   assign instr_o            = r_instr;
   assign instr_pc_o         = r_instr_pc;
   assign instr_xcpt_o       = r_instr_xcpt;
   assign icache_req_valid_o = w_req_valid;
   assign icache_req_addr_o  = {r_pc[ADDR_W-1:ICACHE_OFFSET_W], {ICACHE_OFFSET_W{1'b0}}};
   assign icache_kill_o      = w_kill;

endmodule

// File: tb/tb_icache_interface.sv
// Directed bench for icache_interface; line-buffer expectations follow ICACHE_LINE_BUF_EN.
module tb_icache_interface;

   logic          clk_i = 1'b0;
   logic          rstn_i;
   logic          fetch_valid_i;
   logic [39:0]   fetch_pc_i;
   logic          stall_i;
   logic          flush_i;
   logic          fetch_ready_o;
   logic          instr_valid_o;
   logic [31:0]   instr_o;
   logic [39:0]   instr_pc_o;
   logic          instr_xcpt_o;
   logic          icache_req_valid_o;
   logic          icache_req_ready_i;
   logic [39:0]   icache_req_addr_o;
   logic          icache_kill_o;
   logic          icache_resp_valid_i;
   logic [127:0]  icache_resp_data_i;
   logic          icache_resp_xcpt_i;

   int n_checks = 0;
   int n_pass   = 0;
   int req_cnt  = 0;
   int kill_cnt = 0;

   always #5 clk_i = ~clk_i;

   icache_interface dut (
      .clk_i               (clk_i),
      .rstn_i              (rstn_i),
      .fetch_valid_i       (fetch_valid_i),
      .fetch_pc_i          (fetch_pc_i),
      .stall_i             (stall_i),
      .flush_i             (flush_i),
      .fetch_ready_o       (fetch_ready_o),
      .instr_valid_o       (instr_valid_o),
      .instr_o             (instr_o),
      .instr_pc_o          (instr_pc_o),
      .instr_xcpt_o        (instr_xcpt_o),
      .icache_req_valid_o  (icache_req_valid_o),
      .icache_req_ready_i  (icache_req_ready_i),
      .icache_req_addr_o   (icache_req_addr_o),
      .icache_kill_o       (icache_kill_o),
      .icache_resp_valid_i (icache_resp_valid_i),
      .icache_resp_data_i  (icache_resp_data_i),
      .icache_resp_xcpt_i  (icache_resp_xcpt_i)
   );

   always @(posedge clk_i) begin
      if (icache_req_valid_o && icache_req_ready_i) req_cnt++;
      if (icache_kill_o) kill_cnt++;
   end

   task automatic cyc();
      @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rstn_i = 1'b0; fetch_valid_i = 1'b0; fetch_pc_i = '0; stall_i = 1'b0; flush_i = 1'b0;
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b0; icache_resp_data_i = '0;
      icache_resp_xcpt_i = 1'b0;
      #12;
      n_checks++;
      if ({fetch_ready_o, instr_valid_o, instr_o, instr_pc_o, instr_xcpt_o,
           icache_req_valid_o, icache_req_addr_o, icache_kill_o} !== '0)
         $display("FAIL reset_outputs got rdy=%b vld=%b req=%b kill=%b addr=%h exp all 0",
                  fetch_ready_o, instr_valid_o, icache_req_valid_o, icache_kill_o, icache_req_addr_o);
      else n_pass++;
      @(negedge clk_i); rstn_i = 1'b1;
      cyc();
      icache_resp_valid_i = 1'b1; icache_resp_data_i = {4{32'hFFFF_FFFF}};
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_valid_o, fetch_ready_o} !== 2'b01)
         $display("FAIL reset_unsolicited_resp got vld=%b rdy=%b exp vld=0 rdy=1", instr_valid_o, fetch_ready_o);
      else n_pass++;
   endtask

   task automatic test_basic_miss();
      cyc();
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0008; #1;
      n_checks++;
      if (fetch_ready_o !== 1'b1) $display("FAIL basic_fetch_ready got %b exp 1", fetch_ready_o);
      else n_pass++;
      cyc();
      fetch_valid_i = 1'b0; icache_req_ready_i = 1'b1; #1;
      n_checks++;
      if (icache_req_valid_o !== 1'b1) $display("FAIL basic_req_valid got %b exp 1", icache_req_valid_o);
      else n_pass++;
      n_checks++;
      if (icache_req_addr_o !== 40'h00_4000_0000)
         $display("FAIL basic_req_addr got %h exp %h", icache_req_addr_o, 40'h00_4000_0000);
      else n_pass++;
      cyc();
      icache_req_ready_i = 1'b0;
      cyc();
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i = {32'hDEAD_0003, 32'h0000_0513, 32'hDEAD_0001, 32'hDEAD_0000}; #1;
      n_checks++;
      if (instr_valid_o !== 1'b0) $display("FAIL basic_no_early_valid got %b exp 0", instr_valid_o);
      else n_pass++;
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_valid_o, instr_o, instr_pc_o, instr_xcpt_o} !== {1'b1, 32'h0000_0513, 40'h00_4000_0008, 1'b0})
         $display("FAIL basic_output got vld=%b instr=%h pc=%h x=%b exp vld=1 instr=00000513 pc=0040000008 x=0",
                  instr_valid_o, instr_o, instr_pc_o, instr_xcpt_o);
      else n_pass++;
      cyc();
      n_checks++;
      if (instr_valid_o !== 1'b0) $display("FAIL basic_valid_clears got %b exp 0", instr_valid_o);
      else n_pass++;
   endtask

   task automatic test_backpressure();
      int r0;
      r0 = req_cnt;
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0124;
      cyc();
      fetch_valid_i = 1'b0;
      for (int i = 0; i < 4; i++) begin
         icache_req_ready_i = (i == 3); #1;
         n_checks++;
         if ({icache_req_valid_o, icache_req_addr_o} !== {1'b1, 40'h00_4000_0120})
            $display("FAIL backpressure_hold cycle %0d got vld=%b addr=%h exp vld=1 addr=0040000120",
                     i, icache_req_valid_o, icache_req_addr_o);
         else n_pass++;
         cyc();
      end
      icache_req_ready_i = 1'b0;
      n_checks++;
      if (req_cnt - r0 !== 1) $display("FAIL backpressure_req_count got %0d exp 1", req_cnt - r0);
      else n_pass++;
      icache_resp_valid_i = 1'b1;
      icache_resp_data_i = {32'h0, 32'h0, 32'h1234_5678, 32'hCAFE_0000};
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if (instr_o !== 32'h1234_5678) $display("FAIL backpressure_word1 got %h exp 12345678", instr_o);
      else n_pass++;
      cyc();
   endtask

   task automatic test_flush_wait();
      int k0;
      k0 = kill_cnt;
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0300;
      cyc();
      fetch_valid_i = 1'b0; icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; flush_i = 1'b1; #1;
      n_checks++;
      if (icache_kill_o !== 1'b1) $display("FAIL flush_wait_kill got %b exp 1", icache_kill_o);
      else n_pass++;
      cyc();
      flush_i = 1'b0; fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0400; #1;
      n_checks++;
      if ({icache_kill_o, fetch_ready_o} !== 2'b00)
         $display("FAIL flush_drop_state got kill=%b rdy=%b exp 0 0", icache_kill_o, fetch_ready_o);
      else n_pass++;
      cyc();
      cyc();
      icache_resp_valid_i = 1'b1; icache_resp_data_i = {4{32'hBAD0_BAD0}}; #1;
      n_checks++;
      if (fetch_ready_o !== 1'b0) $display("FAIL flush_drop_ready got %b exp 0", fetch_ready_o);
      else n_pass++;
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_valid_o, fetch_ready_o} !== 2'b01)
         $display("FAIL flush_resp_discarded got vld=%b rdy=%b exp vld=0 rdy=1", instr_valid_o, fetch_ready_o);
      else n_pass++;
      n_checks++;
      if (kill_cnt - k0 !== 1) $display("FAIL flush_kill_pulses got %0d exp 1", kill_cnt - k0);
      else n_pass++;
      cyc();
      fetch_valid_i = 1'b0; #1;
      n_checks++;
      if ({icache_req_valid_o, icache_req_addr_o} !== {1'b1, 40'h00_4000_0400})
         $display("FAIL flush_new_fetch got vld=%b addr=%h exp vld=1 addr=0040000400",
                  icache_req_valid_o, icache_req_addr_o);
      else n_pass++;
   endtask

   task automatic test_flush_req();
      int r0;
      r0 = req_cnt;
      flush_i = 1'b1; icache_req_ready_i = 1'b0; #1;
      n_checks++;
      if ({icache_req_valid_o, icache_kill_o} !== 2'b00)
         $display("FAIL flush_req_deassert got vld=%b kill=%b exp 0 0", icache_req_valid_o, icache_kill_o);
      else n_pass++;
      cyc();
      flush_i = 1'b0; #1;
      n_checks++;
      if ({fetch_ready_o, icache_req_valid_o} !== 2'b10)
         $display("FAIL flush_req_idle got rdy=%b vld=%b exp rdy=1 vld=0", fetch_ready_o, icache_req_valid_o);
      else n_pass++;
      n_checks++;
      if (req_cnt !== r0) $display("FAIL flush_req_no_accept got %0d exp 0", req_cnt - r0);
      else n_pass++;
   endtask

   task automatic test_stall();
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0508;
      cyc();
      fetch_valid_i = 1'b0; icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1;
      icache_resp_data_i = {32'h0, 32'hAAAA_5555, 32'h0, 32'h0};
      cyc();
      icache_resp_valid_i = 1'b0; icache_resp_data_i = '1; stall_i = 1'b1;
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0700;
      for (int i = 0; i < 5; i++) begin
         #1;
         n_checks++;
         if ({instr_valid_o, instr_o, instr_pc_o, instr_xcpt_o, fetch_ready_o, icache_req_valid_o} !==
             {1'b1, 32'hAAAA_5555, 40'h00_4000_0508, 1'b0, 1'b0, 1'b0})
            $display("FAIL stall_frozen cycle %0d got vld=%b instr=%h pc=%h rdy=%b req=%b exp 1 aaaa5555 0040000508 0 0",
                     i, instr_valid_o, instr_o, instr_pc_o, fetch_ready_o, icache_req_valid_o);
         else n_pass++;
         cyc();
      end
      stall_i = 1'b0; fetch_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_valid_o, fetch_ready_o} !== 2'b11)
         $display("FAIL stall_release got vld=%b rdy=%b exp 1 1", instr_valid_o, fetch_ready_o);
      else n_pass++;
      cyc();
      n_checks++;
      if (instr_valid_o !== 1'b0) $display("FAIL stall_valid_drops got %b exp 0", instr_valid_o);
      else n_pass++;
   endtask

   task automatic test_fault();
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_060C;
      cyc();
      fetch_valid_i = 1'b0; icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1; icache_resp_xcpt_i = 1'b1;
      icache_resp_data_i = {32'hBBBB_0000, 96'h0};
      cyc();
      icache_resp_valid_i = 1'b0; icache_resp_xcpt_i = 1'b0; stall_i = 1'b1; flush_i = 1'b1; #1;
      n_checks++;
      if ({instr_valid_o, instr_xcpt_o, instr_pc_o, instr_o} !== {1'b1, 1'b1, 40'h00_4000_060C, 32'hBBBB_0000})
         $display("FAIL fault_output got vld=%b x=%b pc=%h instr=%h exp 1 1 004000060c bbbb0000",
                  instr_valid_o, instr_xcpt_o, instr_pc_o, instr_o);
      else n_pass++;
      cyc();
      flush_i = 1'b0; #1;
      n_checks++;
      if (instr_valid_o !== 1'b0) $display("FAIL flush_over_stall got %b exp 0", instr_valid_o);
      else n_pass++;
      stall_i = 1'b0;
      cyc();
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0600;
      cyc();
      fetch_valid_i = 1'b0; #1;
      n_checks++;
      if ({icache_req_valid_o, icache_req_addr_o} !== {1'b1, 40'h00_4000_0600})
         $display("FAIL fault_refetch_req got vld=%b addr=%h exp 1 0040000600", icache_req_valid_o, icache_req_addr_o);
      else n_pass++;
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1; icache_resp_data_i = {96'h0, 32'h1111_0000};
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_o, instr_xcpt_o} !== {32'h1111_0000, 1'b0})
         $display("FAIL fault_refetch_data got instr=%h x=%b exp 11110000 0", instr_o, instr_xcpt_o);
      else n_pass++;
      cyc();
   endtask

   task automatic test_back_to_back();
      int r0;
      r0 = req_cnt;
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0000;
      cyc();
      fetch_valid_i = 1'b0; icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1;
      icache_resp_data_i = {32'h3, 32'h2, 32'h0010_0093, 32'h0000_0013};
      cyc();
      icache_resp_valid_i = 1'b0; fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0004; #1;
      n_checks++;
      if ({instr_o, fetch_ready_o} !== {32'h0000_0013, 1'b1})
         $display("FAIL b2b_first got instr=%h rdy=%b exp 00000013 1", instr_o, fetch_ready_o);
      else n_pass++;
      cyc();
      fetch_valid_i = 1'b0; #1;
`ifdef ICACHE_LINE_BUF_EN
      n_checks++;
      if ({instr_valid_o, instr_o, instr_pc_o, icache_req_valid_o} !==
          {1'b1, 32'h0010_0093, 40'h00_4000_0004, 1'b0})
         $display("FAIL b2b_hit got vld=%b instr=%h pc=%h req=%b exp 1 00100093 0040000004 0",
                  instr_valid_o, instr_o, instr_pc_o, icache_req_valid_o);
      else n_pass++;
      n_checks++;
      if (req_cnt - r0 !== 1) $display("FAIL b2b_req_count got %0d exp 1", req_cnt - r0);
      else n_pass++;
`else
      n_checks++;
      if ({instr_valid_o, icache_req_valid_o, icache_req_addr_o} !== {1'b0, 1'b1, 40'h00_4000_0000})
         $display("FAIL b2b_second_req got vld=%b req=%b addr=%h exp 0 1 0040000000",
                  instr_valid_o, icache_req_valid_o, icache_req_addr_o);
      else n_pass++;
      icache_req_ready_i = 1'b1;
      cyc();
      icache_req_ready_i = 1'b0; icache_resp_valid_i = 1'b1;
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_o, instr_pc_o} !== {32'h0010_0093, 40'h00_4000_0004})
         $display("FAIL b2b_second_data got instr=%h pc=%h exp 00100093 0040000004", instr_o, instr_pc_o);
      else n_pass++;
      n_checks++;
      if (req_cnt - r0 !== 2) $display("FAIL b2b_req_count got %0d exp 2", req_cnt - r0);
      else n_pass++;
`endif
      cyc();
   endtask

   task automatic test_reset_mid();
      fetch_valid_i = 1'b1; fetch_pc_i = 40'h00_4000_0800;
      cyc();
      fetch_valid_i = 1'b0; #1;
      n_checks++;
      if (icache_req_valid_o !== 1'b1) $display("FAIL reset_mid_pre got %b exp 1", icache_req_valid_o);
      else n_pass++;
      rstn_i = 1'b0; #1;
      n_checks++;
      if ({icache_req_valid_o, fetch_ready_o, instr_valid_o} !== 3'b000)
         $display("FAIL reset_mid_async got req=%b rdy=%b vld=%b exp 0 0 0",
                  icache_req_valid_o, fetch_ready_o, instr_valid_o);
      else n_pass++;
      @(negedge clk_i); rstn_i = 1'b1;
      cyc();
      icache_resp_valid_i = 1'b1; icache_resp_data_i = '1;
      cyc();
      icache_resp_valid_i = 1'b0; #1;
      n_checks++;
      if ({instr_valid_o, fetch_ready_o} !== 2'b01)
         $display("FAIL reset_mid_ignore_resp got vld=%b rdy=%b exp 0 1", instr_valid_o, fetch_ready_o);
      else n_pass++;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog timeout");
      $fatal(1);
   end

   initial begin
      test_reset();
      test_basic_miss();
      test_backpressure();
      test_flush_wait();
      test_flush_req();
      test_stall();
      test_fault();
      test_back_to_back();
      test_reset_mid();
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

// File: doc/icache_interface.md
Name: icache_interface

Overview:
- Fetch-side adapter between the IF stage and the instruction cache.
- Turns per-PC fetch requests into one-outstanding icache line requests with a valid/ready handshake.
- Selects the 32-bit instruction from the returned 128-bit line and holds the result stable while decode stalls.
- On a jump/flush, cancels any outstanding miss: the next response is discarded so stale instructions never enter IF/ID.

Parameters:
ADDR_W, 40, physical/virtual PC width
LINE_W, 128, icache response line width in bits
INSTR_W, 32, instruction width

Ports:
clk_i  in  1  clock
rstn_i  in  1  asynchronous active-low reset
fetch_valid_i  in  1  IF stage requests instruction at fetch_pc_i
fetch_pc_i  in  ADDR_W  fetch PC, 4-byte aligned
stall_i  in  1  decode stall: hold the presented instruction
flush_i  in  1  jump/exception redirect: kill in-flight fetch
fetch_ready_o  out  1  block can accept a new PC this cycle
instr_valid_o  out  1  instr_o/instr_pc_o valid
instr_o  out  INSTR_W  fetched instruction
instr_pc_o  out  ADDR_W  PC of instr_o
instr_xcpt_o  out  1  fetch access fault on this instruction
icache_req_valid_o  out  1  line request valid
icache_req_ready_i  in  1  icache accepts request
icache_req_addr_o  out  ADDR_W  line-aligned address (low 4 bits zero)
icache_kill_o  out  1  one-cycle pulse: abandon outstanding request
icache_resp_valid_i  in  1  response line valid
icache_resp_data_i  in  LINE_W  response line
icache_resp_xcpt_i  in  1  response access fault

Behaviour:
- Reset values:
  - State IDLE; all outputs 0.
  - Line buffer invalid; pending PC register 0.
- FSM states: IDLE, REQ, WAIT, DROP.
- IDLE:
  - fetch_ready_o=1 when the output is free, i.e. !instr_valid_o or !stall_i.
  - On fetch_valid_i & fetch_ready_o, latch the PC and go to REQ.
- REQ:
  - icache_req_valid_o=1; icache_req_addr_o = {pc[ADDR_W-1:4],4'b0}, held stable until accepted.
  - On icache_req_ready_i, go to WAIT.
  - flush_i in REQ: deassert the request the same cycle and go to IDLE. No kill is needed because nothing was accepted.
  - flush_i and icache_req_ready_i in the same cycle: the request counts as accepted; assert icache_kill_o and go to DROP.
- WAIT:
  - On icache_resp_valid_i, register the output:
    - instr_o = data[pc[3:2]*32 +: 32]
    - instr_pc_o = pc
    - instr_xcpt_o = icache_resp_xcpt_i
    - instr_valid_o = 1
  - Then go to IDLE.
  - Miss latency: response cycle +1.
  - flush_i in WAIT: pulse icache_kill_o and go to DROP.
  - flush_i in the same cycle as icache_resp_valid_i: drop the data, no output, go to IDLE.
- DROP:
  - fetch_ready_o=0.
  - Discard the first icache_resp_valid_i, then go to IDLE.
  - Further flush_i in DROP has no effect.
- Output register:
  - While stall_i=1 and instr_valid_o=1, instr_o, instr_pc_o and instr_xcpt_o are frozen.
  - When stall_i=0 and no new instruction is loaded, instr_valid_o clears the next cycle.
  - flush_i clears instr_valid_o the next cycle, with priority over stall_i.
- Exactly one outstanding icache request at any time.
- Reset mid-operation returns to IDLE immediately. A later unsolicited icache response is ignored in IDLE.

Optional Feature:
- Macro ICACHE_LINE_BUF_EN.
- Enabled:
  - A 128-bit line buffer keeps the last valid, non-faulting response line with its tag pc[ADDR_W-1:4].
  - In IDLE, an accepted fetch whose tag matches a valid buffer skips the icache: the output is registered next cycle (1-cycle hit latency), no request is issued, and the state stays IDLE.
  - The buffer is invalidated on flush_i, on a faulting response, and on reset.
- Disabled: every fetch issues an icache request; no line storage is built.

Decomposition:
- Package drac_pkg gets:
  - the typedef icache_if_state_t {IDLE, REQ, WAIT, DROP};
  - the constants ICACHE_LINE_W=128 and ICACHE_OFFSET_W=4;
  - a struct icache_line_buf_t {valid, tag, data}.
- One natural sub-module: icache_line_buffer (tag compare, word select, invalidate), instantiated only under ICACHE_LINE_BUF_EN.

Test Plan:
- Basic miss:
  - Stimulus: fetch pc=0x0040000008; req_ready same cycle; response 2 cycles later with data word2=0x00000513.
  - Required: icache_req_addr_o=0x0040000000; instr_o=0x00000513 and instr_pc_o=0x0040000008 one cycle after the response.
- Backpressure: icache_req_ready_i low for 3 cycles → req_valid and addr stable for all 4 cycles, exactly one request accepted.
- Flush in WAIT:
  - Stimulus: flush_i one cycle after acceptance; the response arrives later.
  - Required: icache_kill_o pulses for 1 cycle, the response is discarded with no instr_valid_o, and a new fetch is accepted the cycle after the response.
- Decode stall: instr_valid_o=1 with stall_i high for 5 cycles → outputs frozen, fetch_ready_o=0; stall released → instr_valid_o drops next cycle.
- Fault: icache_resp_xcpt_i=1 → instr_valid_o=1, instr_xcpt_o=1; with ICACHE_LINE_BUF_EN, a refetch of the same line issues a new request.
- Line buffer hit (ICACHE_LINE_BUF_EN):
  - Stimulus: fetches 0x0040000000 then 0x0040000004.
  - Required: one icache request only; the second instruction appears 1 cycle after its fetch.
  - Repeat without the macro: two requests observed.
